// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC predictor: counter encoding,
// BTB entry layout and saturating counter helpers.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    // Tag is stored zero-extended to full address width so any BTB depth fits.
    typedef struct packed {
        logic                  valid;
        logic [FETCH_XLEN-1:0] tag;
        logic [FETCH_XLEN-1:0] target;
        ctr_t                  ctr;
    } btb_entry_t;

    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'b01);
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'b01);
    endfunction

endpackage

// File: rtl/pc_btb_table.sv
// Direct-mapped BTB storage: two combinational read ports (fetch lookup and
// train read-back) and one synchronous write port.
module pc_btb_table
    import fetch_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [IDX_W-1:0]      i_lk_idx,
    output logic                  o_lk_valid,
    output logic [FETCH_XLEN-1:0] o_lk_tag,
    output logic [FETCH_XLEN-1:0] o_lk_target,
    output logic [1:0]            o_lk_ctr,
    input  logic [IDX_W-1:0]      i_up_idx,
    output logic                  o_up_valid,
    output logic [FETCH_XLEN-1:0] o_up_tag,
    output logic [FETCH_XLEN-1:0] o_up_target,
    output logic [1:0]            o_up_ctr,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic                  i_wr_valid,
    input  logic [FETCH_XLEN-1:0] i_wr_tag,
    input  logic [FETCH_XLEN-1:0] i_wr_target,
    input  logic [1:0]            i_wr_ctr
);

    localparam int DEPTH = 1 << IDX_W;

    btb_entry_t r_mem [DEPTH];

    // NOTE: this array is reset because valid bits and counters have defined
    // reset values; a plain data RAM without that need should not be reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= '{valid: i_wr_valid, tag: i_wr_tag,
                                 target: i_wr_target, ctr: i_wr_ctr};
        end
    end

    assign o_lk_valid  = r_mem[i_lk_idx].valid;
    assign o_lk_tag    = r_mem[i_lk_idx].tag;
    assign o_lk_target = r_mem[i_lk_idx].target;
    assign o_lk_ctr    = r_mem[i_lk_idx].ctr;

    assign o_up_valid  = r_mem[i_up_idx].valid;
    assign o_up_tag    = r_mem[i_up_idx].tag;
    assign o_up_target = r_mem[i_up_idx].target;
    assign o_up_ctr    = r_mem[i_up_idx].ctr;

endmodule

// File: rtl/pc_predict_fetch.sv
// Fetch PC register with zero-bubble BTB prediction, redirect/stall priority
// and 2-bit saturating counter training.
module pc_predict_fetch
    import fetch_pkg::*;
#(
    parameter int              XLEN        = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              BTB_ENTRIES = 16
) (
    input  logic            iClk,
    input  logic            iRstN,
    input  logic            iStallF,
    input  logic            iRedirect,
    input  logic [XLEN-1:0] iRedirectPC,
    input  logic            iUpdValid,
    input  logic [XLEN-1:0] iUpdPC,
    input  logic [XLEN-1:0] iUpdTarget,
    input  logic            iUpdTaken,
    output logic [XLEN-1:0] oPC,
    output logic            oPredTaken,
    output logic [XLEN-1:0] oPredTarget
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);

    logic [XLEN-1:0]       r_pc;
    logic [XLEN-1:0]       w_next_pc;

    logic [IDX_W-1:0]      w_lk_idx;
    logic [FETCH_XLEN-1:0] w_lk_tag;
    logic                  w_lk_valid;
    logic [FETCH_XLEN-1:0] w_lk_stored_tag;
    logic [FETCH_XLEN-1:0] w_lk_target;
    logic [1:0]            w_lk_ctr;
    logic                  w_lk_hit;

    logic [IDX_W-1:0]      w_up_idx;
    logic [FETCH_XLEN-1:0] w_up_tag;
    logic                  w_up_valid;
    logic [FETCH_XLEN-1:0] w_up_stored_tag;
    logic [FETCH_XLEN-1:0] w_up_target;
    logic [1:0]            w_up_ctr;
    logic                  w_up_hit;

    logic                  w_wr_en;
    logic                  w_wr_valid;
    logic [FETCH_XLEN-1:0] w_wr_tag;
    logic [FETCH_XLEN-1:0] w_wr_target;
    ctr_t                  w_wr_ctr;

    // Byte-offset bits of the training PC never reach index or tag.
    logic                  w_unused_upd_lsb;
    assign w_unused_upd_lsb = ^iUpdPC[1:0];

    assign w_lk_idx = r_pc[IDX_W+1:2];
    assign w_lk_tag = FETCH_XLEN'(r_pc[XLEN-1:IDX_W+2]);
    assign w_up_idx = iUpdPC[IDX_W+1:2];
    assign w_up_tag = FETCH_XLEN'(iUpdPC[XLEN-1:IDX_W+2]);

    pc_btb_table #(
        .IDX_W (IDX_W)
    ) u_btb (
        .i_clk       (iClk),
        .i_rst_n     (iRstN),
        .i_lk_idx    (w_lk_idx),
        .o_lk_valid  (w_lk_valid),
        .o_lk_tag    (w_lk_stored_tag),
        .o_lk_target (w_lk_target),
        .o_lk_ctr    (w_lk_ctr),
        .i_up_idx    (w_up_idx),
        .o_up_valid  (w_up_valid),
        .o_up_tag    (w_up_stored_tag),
        .o_up_target (w_up_target),
        .o_up_ctr    (w_up_ctr),
        .i_wr_en     (w_wr_en),
        .i_wr_idx    (w_up_idx),
        .i_wr_valid  (w_wr_valid),
        .i_wr_tag    (w_wr_tag),
        .i_wr_target (w_wr_target),
        .i_wr_ctr    (w_wr_ctr)
    );

    assign w_lk_hit    = w_lk_valid && (w_lk_stored_tag == w_lk_tag);
    assign oPredTaken  = w_lk_hit && w_lk_ctr[1];
    assign oPredTarget = w_lk_hit ? XLEN'(w_lk_target) : '0;

    assign w_up_hit = w_up_valid && (w_up_stored_tag == w_up_tag);

    // NOTE: every output is given a default before the branches so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_valid  = w_up_valid;
        w_wr_tag    = w_up_stored_tag;
        w_wr_target = w_up_target;
        w_wr_ctr    = w_up_ctr;
        if (iUpdValid) begin
            if (w_up_hit) begin
                w_wr_en = 1'b1;
                if (iUpdTaken) begin
                    w_wr_ctr    = ctr_inc(w_up_ctr);
                    w_wr_target = FETCH_XLEN'(iUpdTarget);
                end else begin
                    w_wr_ctr    = ctr_dec(w_up_ctr);
                end
            end else if (iUpdTaken) begin
                w_wr_en     = 1'b1;
                w_wr_valid  = 1'b1;
                w_wr_tag    = w_up_tag;
                w_wr_target = FETCH_XLEN'(iUpdTarget);
                w_wr_ctr    = CTR_WT;
            end
        end
    end

    always_comb begin
        w_next_pc = r_pc + XLEN'(4);
        if (iRedirect) begin
            w_next_pc = iRedirectPC;
        end else if (iStallF) begin
            w_next_pc = r_pc;
        end else if (oPredTaken) begin
            w_next_pc = oPredTarget;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    assign oPC = r_pc;

endmodule

// File: tb/tb_pc_predict_fetch.sv
// Directed self-checking bench for pc_predict_fetch (XLEN=32, RESET_PC=0,
// 16 BTB entries: idx = PC[5:2], tag = PC[31:6]).
module tb_pc_predict_fetch;

    logic        iClk;
    logic        iRstN;
    logic        iStallF;
    logic        iRedirect;
    logic [31:0] iRedirectPC;
    logic        iUpdValid;
    logic [31:0] iUpdPC;
    logic [31:0] iUpdTarget;
    logic        iUpdTaken;
    logic [31:0] oPC;
    logic        oPredTaken;
    logic [31:0] oPredTarget;

    int n_cmp  = 0;
    int n_fail = 0;

    pc_predict_fetch #(
        .XLEN        (32),
        .RESET_PC    (32'h0),
        .BTB_ENTRIES (16)
    ) dut (
        .iClk        (iClk),
        .iRstN       (iRstN),
        .iStallF     (iStallF),
        .iRedirect   (iRedirect),
        .iRedirectPC (iRedirectPC),
        .iUpdValid   (iUpdValid),
        .iUpdPC      (iUpdPC),
        .iUpdTarget  (iUpdTarget),
        .iUpdTaken   (iUpdTaken),
        .oPC         (oPC),
        .oPredTaken  (oPredTaken),
        .oPredTarget (oPredTarget)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #50000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic v, input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        iUpdValid  = v;
        iUpdPC     = pc;
        iUpdTarget = tgt;
        iUpdTaken  = tk;
    endtask

    task automatic redir(input logic v, input logic [31:0] pc);
        iRedirect   = v;
        iRedirectPC = pc;
    endtask

    initial begin
        iRstN = 1'b0;
        iStallF = 1'b0;
        redir(1'b0, 32'h0);
        upd(1'b0, 32'h0, 32'h0, 1'b0);

        // Reset state, then sequential fetch.
        #12;
        chk("reset_pc", oPC, 32'h0);
        chk("reset_pred", {31'b0, oPredTaken}, 32'h0);
        iRstN = 1'b1;
        tick(); chk("seq_pc4", oPC, 32'h4);  chk("seq_pred4", {31'b0, oPredTaken}, 32'h0);
        tick(); chk("seq_pc8", oPC, 32'h8);  chk("seq_pred8", {31'b0, oPredTaken}, 32'h0);
        tick(); chk("seq_pc12", oPC, 32'hC); chk("seq_pred12", {31'b0, oPredTaken}, 32'h0);

        // Allocate 0x10 -> 0x40 while fetching 0x0C; prediction at 0x10 is zero-bubble.
        upd(1'b1, 32'h10, 32'h40, 1'b1);
        tick(); upd(1'b0, 32'h0, 32'h0, 1'b0);
        chk("train_pc", oPC, 32'h10);
        chk("train_pred", {31'b0, oPredTaken}, 32'h1);
        chk("train_tgt", oPredTarget, 32'h40);
        tick(); chk("train_jump", oPC, 32'h40);

        // Stall 5 cycles while training: 3 taken (10->11 sat), 2 not-taken (->01).
        iStallF = 1'b1;
        upd(1'b1, 32'h10, 32'h40, 1'b1);
        tick(); chk("stall_pc1", oPC, 32'h40);
        tick(); chk("stall_pc2", oPC, 32'h40);
        tick(); chk("stall_pc3", oPC, 32'h40);
        upd(1'b1, 32'h10, 32'h40, 1'b0);
        tick(); tick();
        iStallF = 1'b0;
        upd(1'b0, 32'h0, 32'h0, 1'b0);
        redir(1'b1, 32'h10);
        tick(); redir(1'b0, 32'h0);
        chk("sat_wnt_pc", oPC, 32'h10);
        chk("sat_wnt_pred", {31'b0, oPredTaken}, 32'h0);
        chk("sat_wnt_tgt", oPredTarget, 32'h40);
        tick(); chk("sat_wnt_next", oPC, 32'h14);

        // 01 -> 00 (floor), then two taken -> 10 predicts taken again.
        upd(1'b1, 32'h10, 32'h40, 1'b0);
        tick();
        upd(1'b1, 32'h10, 32'h40, 1'b1);
        tick(); tick();
        upd(1'b0, 32'h0, 32'h0, 1'b0);
        redir(1'b1, 32'h10);
        tick(); redir(1'b0, 32'h0);
        chk("floor_pred", {31'b0, oPredTaken}, 32'h1);

        // Same-index lookup and update: lookup uses pre-update counter (10 -> 01 after edge).
        upd(1'b1, 32'h10, 32'h40, 1'b0);
        #1 chk("nobypass_pred", {31'b0, oPredTaken}, 32'h1);
        tick(); upd(1'b0, 32'h0, 32'h0, 1'b0);
        chk("nobypass_next", oPC, 32'h40);
        redir(1'b1, 32'h10);
        tick(); redir(1'b0, 32'h0);
        chk("after_nt_pred", {31'b0, oPredTaken}, 32'h0);

        // Redirect to alias 0x50 together with a taken update (01 -> 10).
        upd(1'b1, 32'h10, 32'h40, 1'b1);
        redir(1'b1, 32'h50);
        tick(); redir(1'b0, 32'h0); upd(1'b0, 32'h0, 32'h0, 1'b0);
        chk("alias_pc", oPC, 32'h50);
        chk("alias_pred", {31'b0, oPredTaken}, 32'h0);
        tick(); chk("alias_next", oPC, 32'h54);
        redir(1'b1, 32'h10);
        tick(); redir(1'b0, 32'h0);
        chk("redir_upd_pred", {31'b0, oPredTaken}, 32'h1);

        // Redirect beats stall.
        iStallF = 1'b1;
        redir(1'b1, 32'h200);
        tick(); redir(1'b0, 32'h0); iStallF = 1'b0;
        chk("prio_pc", oPC, 32'h200);

        // Wrap at the top of the address space.
        redir(1'b1, 32'hFFFF_FFFC);
        tick(); redir(1'b0, 32'h0);
        chk("wrap_pc", oPC, 32'hFFFF_FFFC);
        chk("wrap_pred", {31'b0, oPredTaken}, 32'h0);
        tick(); chk("wrap_next", oPC, 32'h0);

        // Mid-cycle async reset with an update in flight.
        redir(1'b1, 32'h10);
        tick(); redir(1'b0, 32'h0);
        chk("pre_rst_pred", {31'b0, oPredTaken}, 32'h1);
        upd(1'b1, 32'h20, 32'h80, 1'b1);
        #2 iRstN = 1'b0;
        #1 chk("arst_pc", oPC, 32'h0);
        chk("arst_pred", {31'b0, oPredTaken}, 32'h0);
        tick(); upd(1'b0, 32'h0, 32'h0, 1'b0);
        chk("arst_hold_pc", oPC, 32'h0);
        iRstN = 1'b1;
        redir(1'b1, 32'h10);
        tick();
        chk("post_rst_pc", oPC, 32'h10);
        chk("post_rst_pred10", {31'b0, oPredTaken}, 32'h0);
        redir(1'b1, 32'h20);
        tick(); redir(1'b0, 32'h0);
        chk("post_rst_pred20", {31'b0, oPredTaken}, 32'h0);
        tick(); chk("post_rst_next", oPC, 32'h24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
